// File: rtl/median_row_select.sv
// 3x3 median-filter row stage: keeps the last three sorted columns and emits the window median.
// Optional `MEDIAN_EDGE_REPLICATE_EN replicates the first column of each row into the window history.
module median_row_select #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic              line_start,
    input  logic [DATA_W-1:0] L_in,
    input  logic [DATA_W-1:0] M_in,
    input  logic [DATA_W-1:0] S_in,
    output logic [DATA_W-1:0] med_out,
    output logic              out_valid
);

    localparam int unsigned FILL_W = 2;
    localparam logic [FILL_W-1:0] FILL_MAX = FILL_W'(2);

    function automatic logic [DATA_W-1:0] f_min(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [DATA_W-1:0] f_max(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [DATA_W-1:0] f_med3(input logic [DATA_W-1:0] a, input logic [DATA_W-1:0] b,
                                                 input logic [DATA_W-1:0] c);
        return f_max(f_min(a, b), f_min(f_max(a, b), c));
    endfunction

    logic [DATA_W-1:0] r_h1_l, r_h1_m, r_h1_s;
    logic [DATA_W-1:0] r_h2_l, r_h2_m, r_h2_s;
    logic [FILL_W-1:0] r_fill;
    logic [DATA_W-1:0] r_smax, r_mmed, r_lmin;
    logic              r_a_valid;
    logic [DATA_W-1:0] r_med;
    logic              r_out_valid;

    logic              w_first_col;
    logic              w_win_full;
    logic [FILL_W-1:0] w_fill_inc;
    logic [DATA_W-1:0] w_smax, w_mmed, w_lmin;

    // Column that starts a row, and whether the current column closes a full window
    always_comb begin
        w_first_col = 1'b0;
        w_win_full  = 1'b0;
        w_fill_inc  = (r_fill == FILL_MAX) ? FILL_MAX : r_fill + FILL_W'(1);
`ifdef MEDIAN_EDGE_REPLICATE_EN
        w_first_col = in_valid && (line_start || (r_fill == FILL_W'(0)));
`else
        w_first_col = in_valid && line_start;
`endif
        w_win_full  = in_valid && !w_first_col && (r_fill == FILL_MAX);
        w_smax      = f_max(f_max(S_in, r_h1_s), r_h2_s);
        w_mmed      = f_med3(M_in, r_h1_m, r_h2_m);
        w_lmin      = f_min(f_min(L_in, r_h1_l), r_h2_l);
    end

    // Column history and fill tracking
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h1_l <= '0;
            r_h1_m <= '0;
            r_h1_s <= '0;
            r_h2_l <= '0;
            r_h2_m <= '0;
            r_h2_s <= '0;
            r_fill <= '0;
        end else if (in_valid) begin
            r_h1_l <= L_in;
            r_h1_m <= M_in;
            r_h1_s <= S_in;
`ifdef MEDIAN_EDGE_REPLICATE_EN
            if (w_first_col) begin
                r_h2_l <= L_in;
                r_h2_m <= M_in;
                r_h2_s <= S_in;
                r_fill <= FILL_MAX;
            end else begin
                r_h2_l <= r_h1_l;
                r_h2_m <= r_h1_m;
                r_h2_s <= r_h1_s;
                r_fill <= w_fill_inc;
            end
`else
            r_h2_l <= r_h1_l;
            r_h2_m <= r_h1_m;
            r_h2_s <= r_h1_s;
            r_fill <= w_first_col ? FILL_W'(1) : w_fill_inc;
`endif
        end else if (line_start) begin
            r_fill <= '0;
        end
    end

    // Stage A: per-row reductions; Stage B: final median
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_smax      <= '0;
            r_mmed      <= '0;
            r_lmin      <= '0;
            r_a_valid   <= 1'b0;
            r_med       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_a_valid   <= w_win_full;
            if (w_win_full) begin
                r_smax <= w_smax;
                r_mmed <= w_mmed;
                r_lmin <= w_lmin;
            end
            r_out_valid <= r_a_valid;
            if (r_a_valid) begin
                r_med <= f_med3(r_smax, r_mmed, r_lmin);
            end
        end
    end

    assign med_out   = r_med;
    assign out_valid = r_out_valid;

endmodule

// File: tb/tb_median_row_select.sv
// Directed self-checking bench for median_row_select with hand-computed medians.
module tb_median_row_select;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       line_start;
    logic [7:0] L_in;
    logic [7:0] M_in;
    logic [7:0] S_in;
    logic [7:0] med_out;
    logic       out_valid;

    int checks = 0;
    int errors = 0;

    median_row_select #(.DATA_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .line_start (line_start),
        .L_in       (L_in),
        .M_in       (M_in),
        .S_in       (S_in),
        .med_out    (med_out),
        .out_valid  (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of input at a falling edge, then advance to the next falling edge
    task automatic tick(input logic v, input logic ls, input logic [7:0] s, input logic [7:0] m,
                        input logic [7:0] l);
        in_valid   = v;
        line_start = ls;
        S_in       = s;
        M_in       = m;
        L_in       = l;
        @(negedge clk);
    endtask

    task automatic idle();
        tick(1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    endtask

    task automatic chk_v(input string tag, input logic exp_v);
        checks++;
        assert (out_valid === exp_v) else begin
            errors++;
            $error("FAIL %s: out_valid observed %0b expected %0b", tag, out_valid, exp_v);
        end
    endtask

    task automatic chk_vm(input string tag, input logic exp_v, input logic [7:0] exp_m);
        chk_v(tag, exp_v);
        checks++;
        assert (med_out === exp_m) else begin
            errors++;
            $error("FAIL %s: med_out observed %0d expected %0d", tag, med_out, exp_m);
        end
    endtask

    initial begin
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        line_start = 1'b0;
        L_in       = '0;
        M_in       = '0;
        S_in       = '0;
        @(negedge clk);
        @(negedge clk);
        chk_vm("reset_state", 1'b0, 8'd0);
        rst_n = 1'b1;
        @(negedge clk);

`ifdef MEDIAN_EDGE_REPLICATE_EN
        // Window {c1,c0,c0}: smax=2, mmed=5, lmin=7 -> 5
        tick(1'b1, 1'b0, 8'd1, 8'd5, 8'd9);
        chk_vm("rep_c0", 1'b0, 8'd0);
        tick(1'b1, 1'b0, 8'd2, 8'd6, 8'd7);
        chk_vm("rep_c1_stageA", 1'b0, 8'd0);
        idle();
        chk_vm("rep_median", 1'b1, 8'd5);
        idle();
        chk_vm("rep_hold", 1'b0, 8'd5);
        // Next column continues the row: {(3,4,8),(2,6,7),(1,5,9)} -> 3,5,7 -> 5
        tick(1'b1, 1'b0, 8'd3, 8'd4, 8'd8);
        chk_v("rep_c2_stageA", 1'b0);
        idle();
        chk_vm("rep_c2_median", 1'b1, 8'd5);
        // New row replicates (10,11,12); (13,14,15) gives 13,11,12 -> 12
        tick(1'b1, 1'b1, 8'd10, 8'd11, 8'd12);
        chk_v("rep_row_c0", 1'b0);
        tick(1'b1, 1'b0, 8'd13, 8'd14, 8'd15);
        chk_v("rep_row_c1_stageA", 1'b0);
        idle();
        chk_vm("rep_row_median", 1'b1, 8'd12);
        idle();
        chk_vm("rep_row_hold", 1'b0, 8'd12);
        // Idle line_start then a fresh first column replicates again: (20,21,22)+(30,31,32) -> 30,21,22 -> 22
        tick(1'b0, 1'b1, 8'd0, 8'd0, 8'd0);
        chk_v("rep_ls_idle", 1'b0);
        tick(1'b1, 1'b0, 8'd20, 8'd21, 8'd22);
        chk_v("rep_ls_c0", 1'b0);
        tick(1'b1, 1'b0, 8'd30, 8'd31, 8'd32);
        chk_v("rep_ls_c1", 1'b0);
        idle();
        chk_vm("rep_ls_median", 1'b1, 8'd22);
`else
        // Basic window: smax=3, mmed=5, lmin=7 -> 5
        tick(1'b1, 1'b0, 8'd1, 8'd5, 8'd9);
        chk_vm("basic_c0", 1'b0, 8'd0);
        tick(1'b1, 1'b0, 8'd2, 8'd6, 8'd7);
        chk_vm("basic_c1", 1'b0, 8'd0);
        tick(1'b1, 1'b0, 8'd3, 8'd4, 8'd8);
        chk_vm("basic_c2_stageA", 1'b0, 8'd0);
        // Streaming: window (2,6,7),(3,4,8),(10,20,30): smax=10, mmed=6, lmin=7 -> 7
        tick(1'b1, 1'b0, 8'd10, 8'd20, 8'd30);
        chk_vm("basic_median", 1'b1, 8'd5);
        idle();
        chk_vm("stream_median", 1'b1, 8'd7);
        idle();
        chk_vm("stream_hold", 1'b0, 8'd7);

        // Gap: new row, 3 idle cycles between 3rd and 4th column
        tick(1'b1, 1'b1, 8'd1, 8'd5, 8'd9);
        chk_v("gap_c0", 1'b0);
        tick(1'b1, 1'b0, 8'd2, 8'd6, 8'd7);
        chk_v("gap_c1", 1'b0);
        tick(1'b1, 1'b0, 8'd3, 8'd4, 8'd8);
        chk_v("gap_c2", 1'b0);
        idle();
        chk_vm("gap_c2_median", 1'b1, 8'd5);
        idle();
        chk_vm("gap_idle2", 1'b0, 8'd5);
        idle();
        chk_vm("gap_idle3", 1'b0, 8'd5);
        tick(1'b1, 1'b0, 8'd10, 8'd20, 8'd30);
        chk_v("gap_c3_stageA", 1'b0);
        idle();
        chk_vm("gap_c3_median", 1'b1, 8'd7);

        // Row restart with 4th column: window (10,11,12),(13,14,15),(16,17,18) -> 16,14,12 -> 14
        tick(1'b1, 1'b1, 8'd1, 8'd5, 8'd9);
        tick(1'b1, 1'b0, 8'd2, 8'd6, 8'd7);
        tick(1'b1, 1'b0, 8'd3, 8'd4, 8'd8);
        chk_v("rs_c2", 1'b0);
        tick(1'b1, 1'b1, 8'd10, 8'd11, 8'd12);
        chk_vm("rs_c3_prev_median", 1'b1, 8'd5);
        tick(1'b1, 1'b0, 8'd13, 8'd14, 8'd15);
        chk_v("rs_c4", 1'b0);
        tick(1'b1, 1'b0, 8'd16, 8'd17, 8'd18);
        chk_v("rs_c5_stageA", 1'b0);
        idle();
        chk_vm("rs_median", 1'b1, 8'd14);
        idle();
        chk_vm("rs_hold", 1'b0, 8'd14);

        // line_start without in_valid clears fill: (50,60,70),(51,61,71),(52,62,72) -> 52,61,70 -> 61
        tick(1'b0, 1'b1, 8'd0, 8'd0, 8'd0);
        chk_v("ls_idle", 1'b0);
        tick(1'b1, 1'b0, 8'd50, 8'd60, 8'd70);
        chk_v("ls_c0", 1'b0);
        tick(1'b1, 1'b0, 8'd51, 8'd61, 8'd71);
        chk_v("ls_c1", 1'b0);
        tick(1'b1, 1'b0, 8'd52, 8'd62, 8'd72);
        chk_v("ls_c2_stageA", 1'b0);
        idle();
        chk_vm("ls_median", 1'b1, 8'd61);
        idle();

        // Reset one cycle after a completing column discards the in-flight median
        tick(1'b1, 1'b1, 8'd1, 8'd5, 8'd9);
        tick(1'b1, 1'b0, 8'd2, 8'd6, 8'd7);
        tick(1'b1, 1'b0, 8'd3, 8'd4, 8'd8);
        chk_vm("rst_pre", 1'b0, 8'd61);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk_vm("rst_immediate", 1'b0, 8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        chk_vm("rst_after1", 1'b0, 8'd0);
        idle();
        chk_vm("rst_after2", 1'b0, 8'd0);
        // Fill restarted from zero: two columns alone make no window
        tick(1'b1, 1'b0, 8'd4, 8'd4, 8'd4);
        tick(1'b1, 1'b0, 8'd5, 8'd5, 8'd5);
        idle();
        chk_vm("rst_warmup1", 1'b0, 8'd0);
        idle();
        chk_vm("rst_warmup2", 1'b0, 8'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog so the bench always terminates
    initial begin
        #100000;
        $display("FAIL watchdog: simulation observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
